// File: rtl/data_trigger_ctrl_pkg.sv
// Shared types and reset defaults for the data_trigger run/stop and configuration sequencer.
// ADC_RESOLUTION_WIDTH normally comes from the trigger's macro file; 12 bits is assumed if it is absent.
`ifndef ADC_RESOLUTION_WIDTH
`define ADC_RESOLUTION_WIDTH 12
`endif

package data_trigger_ctrl_pkg;

  localparam int unsigned DATA_W     = `ADC_RESOLUTION_WIDTH + 1;
  localparam int unsigned PRE_LEN_W  = $clog2(2);
  localparam int unsigned POST_LEN_W = $clog2(2);
  localparam int unsigned SEL_LEN_W  = $clog2(4);

  localparam int DEF_RISE = 1024;
  localparam int DEF_FALL = 512;
  localparam int DEF_PRE  = 1;
  localparam int DEF_POST = 1;
  localparam int DEF_SEL  = 2;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUNNING = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_APPLY   = 3'd4,
    ST_RESUME  = 3'd5
  } ctrl_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] rise;
    logic signed [DATA_W-1:0] fall;
    logic [PRE_LEN_W-1:0]     pre;
    logic [POST_LEN_W-1:0]    post;
    logic [SEL_LEN_W-1:0]     sel;
  } trig_cfg_t;

endpackage

// File: rtl/data_trigger_ctrl_drain.sv
// drain_detector: counts consecutive idle TVALID cycles while enabled and flags the terminal count.
module drain_detector #(
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tvalid,
  output logic done
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && !tvalid && (cnt_q == CNT_W'(DRAIN_CYCLES - 1));
    cnt_d = cnt_q;
    if (!en || tvalid || done) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/data_trigger_ctrl.sv
// Run/stop and configuration sequencer in front of data_trigger; configs are applied only after the output drains.
// Optional APPLY_COUNT output is enabled by defining DATA_TRIGGER_CTRL_APPLY_COUNTER_EN.
module data_trigger_ctrl
  import data_trigger_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PRE_ACQUISITION_LENGTH      = 2,
  parameter int unsigned MAX_POST_ACQUISITION_LENGTH     = 2,
  parameter int unsigned MAX_ADC_SELECTION_PERIOD_LENGTH = 4,
  parameter int unsigned DRAIN_CYCLES                    = 8,
  parameter int          DEF_RISE                        = data_trigger_ctrl_pkg::DEF_RISE,
  parameter int          DEF_FALL                        = data_trigger_ctrl_pkg::DEF_FALL,
  parameter int          DEF_PRE                         = data_trigger_ctrl_pkg::DEF_PRE,
  parameter int          DEF_POST                        = data_trigger_ctrl_pkg::DEF_POST,
  parameter int          DEF_SEL                         = data_trigger_ctrl_pkg::DEF_SEL
) (
  input  logic                                               ACLK,
  input  logic                                               ARESETN,
  input  logic                                               CMD_START,
  input  logic                                               CMD_HALT,
  input  logic                                               CFG_VALID,
  output logic                                               CFG_READY,
  input  logic signed [DATA_W-1:0]                           CFG_RISE,
  input  logic signed [DATA_W-1:0]                           CFG_FALL,
  input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH)-1:0]      CFG_PRE,
  input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH)-1:0]     CFG_POST,
  input  logic [$clog2(MAX_ADC_SELECTION_PERIOD_LENGTH)-1:0] CFG_SEL,
  output logic                                               CFG_ERR,
  input  logic                                               M_AXIS_TVALID,
  output logic                                               STOP,
  output logic                                               SET_CONFIG,
  output logic signed [DATA_W-1:0]                           RISING_EDGE_THRSHOLD,
  output logic signed [DATA_W-1:0]                           FALLING_EDGE_THRESHOLD,
  output logic [$clog2(MAX_PRE_ACQUISITION_LENGTH)-1:0]      PRE_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_POST_ACQUISITION_LENGTH)-1:0]     POST_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_ADC_SELECTION_PERIOD_LENGTH)-1:0] ADC_SELECTION_PERIOD_LENGTH,
  output logic [2:0]                                         CTRL_STATE
`ifdef DATA_TRIGGER_CTRL_APPLY_COUNTER_EN
  ,
  output logic [15:0]                                        APPLY_COUNT
`endif
);

  localparam trig_cfg_t DEF_CFG = '{
    rise: DATA_W'(DEF_RISE),
    fall: DATA_W'(DEF_FALL),
    pre:  PRE_LEN_W'(DEF_PRE),
    post: POST_LEN_W'(DEF_POST),
    sel:  SEL_LEN_W'(DEF_SEL)
  };

  ctrl_state_e state_q, state_d;
  logic        resume_q, resume_d;
  trig_cfg_t   shadow_q, shadow_d;
  trig_cfg_t   cfg_out_q, cfg_out_d;
  logic        stop_q, stop_d;
  logic        set_cfg_q, set_cfg_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        cfg_hs, cfg_ok, accept;
  logic        drain_done;

  drain_detector #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_drain (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .en     (state_q == ST_DRAIN),
    .tvalid (M_AXIS_TVALID),
    .done   (drain_done)
  );

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    shadow_d = shadow_q;

    cfg_hs = CFG_VALID && ready_q;
    cfg_ok = !(CFG_FALL > CFG_RISE)
          && (32'(CFG_PRE)  < MAX_PRE_ACQUISITION_LENGTH)
          && (32'(CFG_POST) < MAX_POST_ACQUISITION_LENGTH)
          && (32'(CFG_SEL)  < MAX_ADC_SELECTION_PERIOD_LENGTH);
    accept = cfg_hs && cfg_ok;

    if (accept) shadow_d = '{rise: CFG_RISE, fall: CFG_FALL, pre: CFG_PRE, post: CFG_POST, sel: CFG_SEL};

    case (state_q)
      ST_INIT: begin
        state_d  = ST_APPLY;
        resume_d = 1'b0;
      end
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_DRAIN;
          resume_d = 1'b0;
        end else if (CMD_START && !CMD_HALT) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (accept) begin
          state_d  = ST_DRAIN;
          resume_d = !CMD_HALT;
        end else if (CMD_HALT) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (CMD_HALT)   resume_d = 1'b0;
        if (drain_done) state_d  = ST_APPLY;
      end
      ST_APPLY:  state_d = resume_q ? ST_RESUME : ST_IDLE;
      ST_RESUME: state_d = ST_RUNNING;
      default:   state_d = ST_INIT;
    endcase

    // Status flags follow the next state so they land on the same edge as the state change;
    // the config strobe lags APPLY by one edge so outputs and SET_CONFIG move together.
    stop_d    = (state_d != ST_RUNNING);
    ready_d   = (state_d == ST_IDLE) || (state_d == ST_RUNNING);
    err_d     = cfg_hs && !cfg_ok;
    set_cfg_d = (state_q == ST_APPLY);
    cfg_out_d = set_cfg_d ? shadow_q : cfg_out_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_INIT;
      resume_q  <= 1'b0;
      shadow_q  <= DEF_CFG;
      cfg_out_q <= DEF_CFG;
      stop_q    <= 1'b1;
      set_cfg_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      shadow_q  <= shadow_d;
      cfg_out_q <= cfg_out_d;
      stop_q    <= stop_d;
      set_cfg_q <= set_cfg_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

`ifdef DATA_TRIGGER_CTRL_APPLY_COUNTER_EN
  logic [15:0] apply_count_q, apply_count_d;

  always_comb begin
    apply_count_d = apply_count_q;
    if (set_cfg_d) apply_count_d = apply_count_q + 16'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) apply_count_q <= '0;
    else          apply_count_q <= apply_count_d;
  end

  assign APPLY_COUNT = apply_count_q;
`endif

  assign CFG_READY                   = ready_q;
  assign CFG_ERR                     = err_q;
  assign STOP                        = stop_q;
  assign SET_CONFIG                  = set_cfg_q;
  assign RISING_EDGE_THRSHOLD        = cfg_out_q.rise;
  assign FALLING_EDGE_THRESHOLD      = cfg_out_q.fall;
  assign PRE_ACQUISITION_LENGTH      = cfg_out_q.pre;
  assign POST_ACQUISITION_LENGTH     = cfg_out_q.post;
  assign ADC_SELECTION_PERIOD_LENGTH = cfg_out_q.sel;
  assign CTRL_STATE                  = state_q;

endmodule

// File: tb/tb_data_trigger_ctrl.sv
// Directed self-checking bench for data_trigger_ctrl: reset defaults, idle/running applies, rejection, halt and reset cases.
module tb_data_trigger_ctrl;
  import data_trigger_ctrl_pkg::*;

  logic                     ACLK = 1'b0;
  logic                     ARESETN;
  logic                     CMD_START, CMD_HALT, CFG_VALID, M_AXIS_TVALID;
  logic signed [DATA_W-1:0] CFG_RISE, CFG_FALL;
  logic [0:0]               CFG_PRE, CFG_POST;
  logic [1:0]               CFG_SEL;
  logic                     CFG_READY, CFG_ERR, STOP, SET_CONFIG;
  logic signed [DATA_W-1:0] RISE_O, FALL_O;
  logic [0:0]               PRE_O, POST_O;
  logic [1:0]               SEL_O;
  logic [2:0]               CTRL_STATE;
`ifdef DATA_TRIGGER_CTRL_APPLY_COUNTER_EN
  logic [15:0]              APPLY_COUNT;
`endif

  int checks   = 0;
  int failures = 0;
  int n;
  int seen;

  always #5 ACLK = ~ACLK;

  data_trigger_ctrl #(
    .DRAIN_CYCLES (8)
  ) dut (
    .ACLK                        (ACLK),
    .ARESETN                     (ARESETN),
    .CMD_START                   (CMD_START),
    .CMD_HALT                    (CMD_HALT),
    .CFG_VALID                   (CFG_VALID),
    .CFG_READY                   (CFG_READY),
    .CFG_RISE                    (CFG_RISE),
    .CFG_FALL                    (CFG_FALL),
    .CFG_PRE                     (CFG_PRE),
    .CFG_POST                    (CFG_POST),
    .CFG_SEL                     (CFG_SEL),
    .CFG_ERR                     (CFG_ERR),
    .M_AXIS_TVALID               (M_AXIS_TVALID),
    .STOP                        (STOP),
    .SET_CONFIG                  (SET_CONFIG),
    .RISING_EDGE_THRSHOLD        (RISE_O),
    .FALLING_EDGE_THRESHOLD      (FALL_O),
    .PRE_ACQUISITION_LENGTH      (PRE_O),
    .POST_ACQUISITION_LENGTH     (POST_O),
    .ADC_SELECTION_PERIOD_LENGTH (SEL_O),
    .CTRL_STATE                  (CTRL_STATE)
`ifdef DATA_TRIGGER_CTRL_APPLY_COUNTER_EN
    ,
    .APPLY_COUNT                 (APPLY_COUNT)
`endif
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input int r, input int f, input int p, input int q, input int s);
    chk({tag, "_rise"}, RISE_O, r);
    chk({tag, "_fall"}, FALL_O, f);
    chk({tag, "_pre"},  PRE_O,  p);
    chk({tag, "_post"}, POST_O, q);
    chk({tag, "_sel"},  SEL_O,  s);
  endtask

  task automatic drive_cfg(input int r, input int f, input int p, input int q, input int s);
    CFG_RISE = DATA_W'(r);
    CFG_FALL = DATA_W'(f);
    CFG_PRE  = 1'(p);
    CFG_POST = 1'(q);
    CFG_SEL  = 2'(s);
  endtask

  // Ticks until SET_CONFIG is seen or the limit expires; returns the tick count.
  task automatic wait_setcfg(input int limit, output int cnt);
    cnt = 0;
    while (SET_CONFIG !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    ARESETN = 1'b0; CMD_START = 1'b0; CMD_HALT = 1'b0; CFG_VALID = 1'b0; M_AXIS_TVALID = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_state", CTRL_STATE, 0);
    chk("rst_stop", STOP, 1);
    chk("rst_setcfg", SET_CONFIG, 0);
    chk("rst_ready", CFG_READY, 0);
    chk("rst_err", CFG_ERR, 0);
    chk_cfg("rst", 1024, 512, 1, 1, 2);

    // Reset release: APPLY after 1st clock, SET_CONFIG on the 2nd.
    ARESETN = 1'b1;
    tick();
    chk("rel1_state", CTRL_STATE, 4);
    chk("rel1_setcfg", SET_CONFIG, 0);
    tick();
    chk("rel2_setcfg", SET_CONFIG, 1);
    chk("rel2_state", CTRL_STATE, 1);
    chk("rel2_stop", STOP, 1);
    chk("rel2_ready", CFG_READY, 1);
    chk_cfg("rel2", 1024, 512, 1, 1, 2);
    tick();
    chk("rel3_setcfg", SET_CONFIG, 0);

    // Config write from IDLE.
    drive_cfg(1500, 700, 1, 1, 3);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
    chk("idle_wr_state", CTRL_STATE, 3);
    chk("idle_wr_ready", CFG_READY, 0);
    chk("idle_wr_hold", RISE_O, 1024);
    wait_setcfg(40, n);
    chk("idle_wr_lat", n, 9);
    chk_cfg("idle_wr", 1500, 700, 1, 1, 3);
    chk("idle_wr_state2", CTRL_STATE, 1);
    chk("idle_wr_stop", STOP, 1);
    tick();
    chk("idle_wr_pulse", SET_CONFIG, 0);

    // Running with busy TVALID.
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
    chk("run_state", CTRL_STATE, 2);
    chk("run_stop", STOP, 0);
    M_AXIS_TVALID = 1'b1;
    drive_cfg(800, 100, 0, 0, 1);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
    chk("busy_stop", STOP, 1);
    chk("busy_state", CTRL_STATE, 3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SET_CONFIG !== 1'b0) seen++;
    end
    chk("busy_no_apply", seen, 0);
    chk_cfg("busy_hold", 1500, 700, 1, 1, 3);
    M_AXIS_TVALID = 1'b0;
    wait_setcfg(40, n);
    chk("busy_lat", n, 9);
    chk_cfg("busy", 800, 100, 0, 0, 1);
    chk("busy_resume_state", CTRL_STATE, 5);
    chk("busy_resume_stop", STOP, 1);
    tick();
    chk("busy_run_state", CTRL_STATE, 2);
    chk("busy_run_stop", STOP, 0);

    // Rejected write: fall > rise.
    drive_cfg(500, 600, 1, 1, 1);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
    chk("rej_err", CFG_ERR, 1);
    chk("rej_state", CTRL_STATE, 2);
    chk("rej_stop", STOP, 0);
    tick();
    chk("rej_err_pulse", CFG_ERR, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (SET_CONFIG !== 1'b0) seen++;
    end
    chk("rej_no_apply", seen, 0);
    chk_cfg("rej", 800, 100, 0, 0, 1);

    // HALT during DRAIN; equal thresholds are legal.
    drive_cfg(300, 300, 1, 0, 2);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
    chk("halt_err", CFG_ERR, 0);
    chk("halt_drain", CTRL_STATE, 3);
    repeat (3) tick();
    CMD_HALT = 1'b1;
    tick();
    CMD_HALT = 1'b0;
    wait_setcfg(40, n);
    chk("halt_lat", n, 5);
    chk_cfg("halt", 300, 300, 1, 0, 2);
    chk("halt_state", CTRL_STATE, 1);
    chk("halt_stop", STOP, 1);
    tick();
    chk("halt_state2", CTRL_STATE, 1);

    // START and HALT together from IDLE.
    CMD_START = 1'b1; CMD_HALT = 1'b1;
    tick();
    CMD_START = 1'b0; CMD_HALT = 1'b0;
    chk("both_state", CTRL_STATE, 1);
    chk("both_stop", STOP, 1);

    // Reset asserted during DRAIN.
    drive_cfg(1000, 0, 0, 0, 0);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
    chk("rdr_drain", CTRL_STATE, 3);
    repeat (2) tick();
    ARESETN = 1'b0;
    #1;
    chk("rdr_state", CTRL_STATE, 0);
    chk("rdr_stop", STOP, 1);
    chk_cfg("rdr", 1024, 512, 1, 1, 2);
    tick();
    ARESETN = 1'b1;
    tick();
    chk("rdr_apply", CTRL_STATE, 4);
    tick();
    chk("rdr_setcfg", SET_CONFIG, 1);
    chk_cfg("rdr_apply", 1024, 512, 1, 1, 2);
    chk("rdr_idle", CTRL_STATE, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (SET_CONFIG !== 1'b0) seen++;
    end
    chk("rdr_discard", seen, 0);
    chk_cfg("rdr_final", 1024, 512, 1, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_trigger_ctrl.md
# data_trigger_ctrl

Run/stop and configuration sequencer for `data_trigger`. It accepts trigger-configuration writes and start/halt commands from the control side, then drives `data_trigger`'s `STOP`, `SET_CONFIG` and threshold/length inputs. A new configuration is never applied while the trigger is still emitting data. Its place in the design is between the PS-side register block and `data_trigger`.

## Interface
Parameters:
- `MAX_PRE_ACQUISITION_LENGTH`, 2: must match `data_trigger`; sets the width of the pre-acquisition length field, $clog2(MAX).
- `MAX_POST_ACQUISITION_LENGTH`, 2: as above, for post-acquisition.
- `MAX_ADC_SELECTION_PERIOD_LENGTH`, 4: as above, for ADC selection period.
- `DRAIN_CYCLES`, 8: number of consecutive idle `M_AXIS_TVALID` cycles required before a configuration is applied.
- `DEF_RISE`, 1024: reset value of the rising-edge threshold.
- `DEF_FALL`, 512: reset value of the falling-edge threshold.
- `DEF_PRE`, 1: reset value of the pre-acquisition length.
- `DEF_POST`, 1: reset value of the post-acquisition length.
- `DEF_SEL`, 2: reset value of the ADC selection period length.

Ports:
- `ACLK`  in  1  single clock for the whole block.
- `ARESETN`  in  1  reset; asynchronous, active-low.
- `CMD_START`  in  1  one-cycle request to enter RUNNING.
- `CMD_HALT`  in  1  one-cycle request to enter IDLE.
- `CFG_VALID`  in  1  configuration write request.
- `CFG_READY`  out  1  block can accept a configuration write.
- `CFG_RISE`, `CFG_FALL`  in  `ADC_RESOLUTION_WIDTH`+1  signed requested thresholds.
- `CFG_PRE`, `CFG_POST`, `CFG_SEL`  in  clog2 widths  requested lengths.
- `CFG_ERR`  out  1  one-cycle pulse when a write is rejected.
- `M_AXIS_TVALID`  in  1  `data_trigger` output valid, used for drain detection.
- `STOP`  out  1  to `data_trigger`.
- `SET_CONFIG`  out  1  to `data_trigger`.
- `RISING_EDGE_THRSHOLD`, `FALLING_EDGE_THRESHOLD`, `PRE_ACQUISITION_LENGTH`, `POST_ACQUISITION_LENGTH`, `ADC_SELECTION_PERIOD_LENGTH`  out  matching widths  configuration to `data_trigger`.
- `CTRL_STATE`  out  3  current state encoding, for status readback.

## Operation
- States: INIT, IDLE, RUNNING, DRAIN, APPLY, RESUME.
- INIT is entered on reset. Outputs hold the DEF_* values; the block moves to APPLY with the resume flag cleared, so the defaults are loaded once.
- IDLE:
  - `STOP`=1.
  - `CMD_START` → RUNNING.
  - Accepted config → DRAIN with resume flag 0.
- RUNNING:
  - `STOP`=0.
  - `CMD_HALT` → IDLE.
  - Accepted config → DRAIN with resume flag 1.
  - Accepted config together with `CMD_HALT` → DRAIN with resume flag 0.
- DRAIN:
  - `STOP`=1.
  - Drain counter increments when `M_AXIS_TVALID`=0 and clears to 0 when it is 1.
  - When the counter reaches `DRAIN_CYCLES`-1 with `M_AXIS_TVALID`=0 → APPLY.
  - `CMD_HALT` in DRAIN clears the resume flag.
- APPLY:
  - Shadow registers are copied to the configuration outputs.
  - `SET_CONFIG`=1 for exactly one cycle.
  - Next state is RESUME if the resume flag is set, otherwise IDLE.
- RESUME: one settle cycle with `STOP`=1, then RUNNING.
- `CFG_READY`=1 only in IDLE and RUNNING.
- Handshake occurs on `CFG_VALID`&&`CFG_READY`.
- Validation: a write is rejected if `CFG_FALL` > `CFG_RISE` (signed compare), or if any length field ≥ its MAX. On rejection:
  - `CFG_ERR` pulses for one cycle;
  - the state and shadow registers are unchanged.
- `CMD_START` together with `CMD_HALT`: HALT wins.
- Commands received in DRAIN, APPLY or RESUME are ignored, apart from HALT as stated above.

## Timing
- Reset values:
  - `STOP`=1, `SET_CONFIG`=0, `CFG_READY`=0, `CFG_ERR`=0;
  - configuration outputs = DEF_*;
  - `CTRL_STATE`=INIT.
- The first `SET_CONFIG` pulse occurs on the 2nd clock after `ARESETN` deasserts.
- All outputs are registered. A state change is visible on outputs one cycle after the triggering input.
- Configuration outputs change only in the cycle `SET_CONFIG`=1 and are stable at all other times.
- Minimum write-to-apply latency from RUNNING is `DRAIN_CYCLES`+2 cycles.
- `ARESETN` asserted mid-sequence returns the block to INIT immediately; a pending shadow configuration is discarded.

## Configuration
- Macro: `DATA_TRIGGER_CTRL_APPLY_COUNTER_EN`.
- When defined:
  - adds output `APPLY_COUNT` (16 bits);
  - it increments on every `SET_CONFIG` pulse, including INIT, and wraps at 0xFFFF→0;
  - it resets to 0.
- When undefined, the port and counter do not exist. All other behaviour is identical.

## Structure
- Shared package `data_trigger_ctrl_pkg` holds:
  - the state enum typedef;
  - a config struct typedef (rise, fall, pre, post, sel);
  - the DEF_* constants.
- Widths come from the existing trigger macros (`ADC_RESOLUTION_WIDTH`).
- One sub-module, `drain_detector`: a counter plus terminal flag, parameterised by `DRAIN_CYCLES`.

## Test plan
- Reset release → `SET_CONFIG` pulses once at cycle 2 with outputs 1024/512/1/1/2; state is then IDLE with `STOP`=1.
- From IDLE, write 1500/700/1/1/3 → one `SET_CONFIG` after 8 idle cycles, outputs updated, state returns to IDLE.
- From RUNNING, with `M_AXIS_TVALID` high for 20 cycles, write a config → `STOP`=1 immediately, `SET_CONFIG` only after 8 consecutive low cycles, `STOP` back to 0 two cycles after APPLY.
- Write with rise=500, fall=600 → `CFG_ERR` pulse, no `SET_CONFIG`, outputs unchanged.
- `CMD_HALT` issued during DRAIN from RUNNING → config applied, state ends in IDLE with `STOP`=1.
- `CMD_START` and `CMD_HALT` in the same cycle from IDLE → stays IDLE; `ARESETN` low during DRAIN → INIT, defaults reapplied.
